conv_bias_relu_seq: RTL and testbench

Sequencer for the per-channel bias stage of a conv2d layer. It accepts a channel-interleaved stream of signed accumulator words and drives the row address of a combinational 16×1 Q1.7 bias ROM from an internal channel counter. For each word it rescales to Q1.7, adds the addressed bias, applies optional ReLU and saturates to 8 bits. It sits between the conv2d MAC array and the next layer's input buffer, with valid/ready handshakes on both sides.

---
 rtl/conv_bias_relu_seq.sv | 150 +++++++++++++++
 tb/tb_conv_bias_relu_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_bias_relu_seq.sv
// Per-channel bias sequencer for a conv2d layer.
// Rescales accumulators to Q1.7, adds the ROM bias, applies ReLU and saturates.
module conv_bias_relu_seq #(
    parameter int NUM_CH     = 16,
    parameter int NUM_PIX    = 1024,
    parameter int ACC_W      = 20,
    parameter int FRAC_SHIFT = 7,
    parameter int RELU_EN    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_acc,
    output logic [15:0]      rom_row,
    output logic [15:0]      rom_col,
    input  logic [7:0]       rom_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [3:0]       out_ch,
    output logic             busy,
    output logic             done
);

    localparam int PW = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam logic [3:0]    CH_LAST  = 4'(NUM_CH - 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(NUM_PIX - 1);
    localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(127);
    localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(-128);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      ch_cnt_q, ch_cnt_d;
    logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;
    logic [3:0]      out_ch_q, out_ch_d;

    logic signed [ACC_W-1:0] acc_shift;
    logic signed [ACC_W:0]   sum;
    logic [7:0]              result;
    logic                    accept;

    // Bias is read combinationally for the beat currently on in_acc.
    always_comb begin
        acc_shift = $signed(in_acc) >>> FRAC_SHIFT;
        sum = {acc_shift[ACC_W-1], acc_shift}
            + {{(ACC_W-7){rom_data[7]}}, rom_data};
        if (RELU_EN != 0 && sum[ACC_W]) begin
            sum = '0;
        end
        if (sum > SAT_HI) begin
            result = 8'h7f;
        end else if (sum < SAT_LO) begin
            result = 8'h80;
        end else begin
            result = sum[7:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_cnt_d    = ch_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        in_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        accept      = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    ch_cnt_d  = '0;
                    pix_cnt_d = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                busy     = 1'b1;
                in_ready = !out_valid_q || out_ready;
                accept   = in_valid && in_ready;
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = result;
                    out_ch_d    = ch_cnt_q;
                    if (ch_cnt_q == CH_LAST) begin
                        ch_cnt_d  = '0;
                        pix_cnt_d = pix_cnt_q + 1'b1;
                        if (pix_cnt_q == PIX_LAST) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        ch_cnt_d = ch_cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (!out_valid_q || out_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ch_cnt_q    <= '0;
            pix_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            ch_cnt_q    <= ch_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign rom_row   = {12'd0, ch_cnt_q};
    assign rom_col   = '0;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_conv_bias_relu_seq.sv
// Scoreboard bench for conv_bias_relu_seq: ReLU and linear instances in lock-step.
// Expected results come from a floor-division/saturation model of the bias stage.
module tb_conv_bias_relu_seq;

    localparam int NCH   = 16;
    localparam int NPIX  = 2;
    localparam int BEATS = NCH * NPIX;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [19:0] in_acc = '0;

    logic        ir_a, ir_b, ov_a, ov_b, busy_a, busy_b, done_a, done_b;
    logic [15:0] row_a, row_b, col_a, col_b;
    logic [7:0]  rd_a, rd_b, od_a, od_b;
    logic [3:0]  och_a, och_b;

    typedef struct {
        int ch;
        int relu;
        int lin;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   pops = 0;

    always #5 clk = ~clk;

    function automatic int bias_of(input int ch);
        case (ch)
            0: return -5;   1: return 0;    2: return 1;    3: return 7;
            4: return 3;    5: return 6;    6: return 1;    7: return 7;
            8: return 12;   9: return 12;   10: return 18;  11: return 18;
            12: return 8;   13: return 8;   14: return 1;   15: return -14;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] rom_lookup(input logic [15:0] row);
        return 8'(bias_of(int'(row)));
    endfunction

    assign rd_a = rom_lookup(row_a);
    assign rd_b = rom_lookup(row_b);

    function automatic int floor128(input int a);
        if (a >= 0) return a / 128;
        return -((-a + 127) / 128);
    endfunction

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic exp_t model(input int acc, input int ch);
        exp_t e;
        int   s;
        s      = floor128(acc) + bias_of(ch);
        e.ch   = ch;
        e.lin  = sat8(s);
        e.relu = sat8((s < 0) ? 0 : s);
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    conv_bias_relu_seq #(
        .NUM_CH(NCH), .NUM_PIX(NPIX), .ACC_W(20), .FRAC_SHIFT(7), .RELU_EN(1)
    ) u_relu (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(ir_a), .in_acc(in_acc),
        .rom_row(row_a), .rom_col(col_a), .rom_data(rd_a),
        .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
        .out_ch(och_a), .busy(busy_a), .done(done_a)
    );

    conv_bias_relu_seq #(
        .NUM_CH(NCH), .NUM_PIX(NPIX), .ACC_W(20), .FRAC_SHIFT(7), .RELU_EN(0)
    ) u_lin (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(ir_b), .in_acc(in_acc),
        .rom_row(row_b), .rom_col(col_b), .rom_data(rd_b),
        .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b),
        .out_ch(och_b), .busy(busy_b), .done(done_b)
    );

    // Monitor: samples mid-cycle, pops on every output handshake.
    initial begin
        exp_t e;
        logic hold_v;
        logic [7:0] hold_d;
        logic [3:0] hold_c;
        hold_v = 1'b0;
        hold_d = '0;
        hold_c = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hold_v = 1'b0;
                continue;
            end
            if (hold_v) begin
                chk("hold_data", int'(od_a), int'(hold_d));
                chk("hold_ch", int'(och_a), int'(hold_c));
            end
            if (done_a) begin
                done_cnt++;
                chk("busy_at_done", int'(busy_a), 0);
                chk("done_b", int'(done_b), 1);
            end
            if (ov_a && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    pops++;
                    chk("out_ch", int'(och_a), e.ch);
                    chk("relu_data", int'($signed(od_a)), e.relu);
                    chk("lin_valid", int'(ov_b), 1);
                    chk("lin_ch", int'(och_b), e.ch);
                    chk("lin_data", int'($signed(od_b)), e.lin);
                end
            end
            hold_v = ov_a && !out_ready;
            hold_d = od_a;
            hold_c = och_a;
        end
    end

    task automatic reset_checks();
        chk("rst_in_ready", int'(ir_a), 0);
        chk("rst_out_valid", int'(ov_a), 0);
        chk("rst_out_data", int'(od_a), 0);
        chk("rst_out_ch", int'(och_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_rom_row", int'(row_a), 0);
        chk("rst_rom_col", int'(col_a), 0);
        chk("rst_lin_valid", int'(ov_b), 0);
    endtask

    function automatic int pick_acc(input int mode, input int ch);
        int sel;
        if (mode == 0) return 640;
        if (mode == 1) begin
            if (ch == 10) return 25600;
            if (ch == 15) return -25600;
            if (ch == 1) return -1;
            return 640;
        end
        sel = int'($urandom_range(0, 3));
        case (sel)
            0: return int'($urandom_range(0, 1048575)) - 524288;
            1: return int'($urandom_range(0, 4000)) - 2000;
            2: return ($urandom_range(0, 1) == 1) ? 524287 : -524288;
            default: return ($urandom_range(0, 1) == 1) ? 25600 : -25600;
        endcase
    endfunction

    // mode 0: fixed 640; mode 1: corner values with 5-cycle stall; mode 2: random.
    task automatic drive_frame(input int mode, input int nbeats, input bit abort);
        int k;
        int cyc;
        int d0;
        int acc;
        k   = 0;
        cyc = 0;
        d0  = done_cnt;
        pops = 0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        while (k < nbeats && cyc < 2000) begin
            acc = pick_acc(mode, k % NCH);
            in_acc = 20'(acc);
            if (mode == 2) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 7);
                start     = ($urandom_range(0, 15) == 0);
            end else begin
                in_valid  = 1'b1;
                out_ready = !(mode == 1 && cyc >= 10 && cyc < 15);
            end
            #1;
            chk("rom_row", int'(row_a), k % NCH);
            chk("rom_col", int'(col_a), 0);
            chk("in_ready", int'(ir_a), int'(!ov_a || out_ready));
            chk("in_ready_lin", int'(ir_b), int'(!ov_a || out_ready));
            if (in_valid && ir_a) begin
                sb.push_back(model(acc, k % NCH));
                k++;
            end
            cyc++;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (abort) begin
            rst = 1'b1;
            sb.delete();
            @(posedge clk);
            @(negedge clk);
            #1;
            reset_checks();
            rst = 1'b0;
            out_ready = 1'b1;
            repeat (4) @(negedge clk);
            chk("abort_no_done", done_cnt, d0);
            return;
        end
        for (int n = 0; n < 100; n++) begin
            out_ready = (mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b1;
            #3;
            chk("in_ready_post", int'(ir_a), 0);
            if (done_cnt != d0) break;
            @(negedge clk);
        end
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        chk("done_once", done_cnt, d0 + 1);
        chk("sb_empty", sb.size(), 0);
        chk("beats_out", pops, nbeats);
        chk("busy_idle", int'(busy_a), 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        reset_checks();
        rst = 1'b0;
        @(negedge clk);
        drive_frame(0, BEATS, 1'b0);
        drive_frame(1, BEATS, 1'b0);
        drive_frame(0, 7, 1'b1);
        drive_frame(0, BEATS, 1'b0);
        for (int f = 0; f < 6; f++) begin
            drive_frame(2, BEATS, 1'b0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
